cam_capture_dvp: RTL

//  Parametrised DVP capture front-end for OV7670/OV7725 sensors. Assembles
//  8-bit byte pairs into pixels (RGB565 or grey from YUV422). Decimates by 1,
//  2 or 4 in each axis and writes pixels to a frame-buffer write port.

---
 rtl/cam_capture_dvp_if.sv | 29 ++
 rtl/cam_capture_dvp.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cam_capture_dvp_if.sv
// Frame-buffer write port plus the sensor pads that feed the DVP capture block.
// master = capture block, slave = whatever drives the pads and consumes writes.
interface cam_capture_dvp_if #(
    parameter int ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
    logic              we;
    logic              wclk;
    logic [11:0]       h_cnt;
    logic [10:0]       v_cnt;
    logic              frame_done;
    logic              line_err;
    logic [ADDR_W-1:0] pix_count;

    modport master (
        input  vsync, href, d, mode,
        output addr, dout, we, wclk, h_cnt, v_cnt, frame_done, line_err, pix_count
    );

    modport slave (
        output vsync, href, d, mode,
        input  addr, dout, we, wclk, h_cnt, v_cnt, frame_done, line_err, pix_count
    );
endinterface

// File: rtl/cam_capture_dvp.sv
// DVP capture front-end: pairs sensor bytes into pixels (RGB565 or grey Y),
// decimates in x and y, writes kept pixels to a frame-buffer port and reports
// per-frame status. Single clock domain (pclk).
module cam_capture_dvp #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DECIM  = 2,
    parameter int ADDR_W = 17
) (
    input  logic                pclk,
    input  logic                rst_n,
    cam_capture_dvp_if.master   bus
);
    localparam int                DSH     = $clog2(DECIM);
    localparam logic [11:0]       X_MASK  = 12'(DECIM - 1);
    localparam logic [10:0]       Y_MASK  = 11'(DECIM - 1);
    localparam logic [11:0]       H_LIM   = 12'(H_RES);
    localparam logic [10:0]       V_LIM   = 11'(V_RES);
    localparam logic [12:0]       LINE_B  = 13'(2 * H_RES);
    localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'((H_RES / DECIM) * (V_RES / DECIM));

    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [11:0]       x_in_q, x_in_d;
    logic [10:0]       y_in_q, y_in_d;
    logic [12:0]       byte_cnt_q, byte_cnt_d;
    logic              mode_q, mode_d;
    logic              frame_sync_q, frame_sync_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic [11:0]       h_cnt_q, h_cnt_d;
    logic [10:0]       v_cnt_q, v_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic [ADDR_W-1:0] pix_count_q, pix_count_d;

    // addr_q points at the write in flight; once it retires, the next free slot
    // is one further on.
    logic [ADDR_W-1:0] addr_inc;
    logic              keep;

    // Next-state: frame sync, byte pairing, decimation filter and status.
    always_comb begin
        vsync_d      = bus.vsync;
        href_d       = bus.href;
        phase_d      = phase_q;
        hi_d         = hi_q;
        x_in_d       = x_in_q;
        y_in_d       = y_in_q;
        byte_cnt_d   = byte_cnt_q;
        mode_d       = mode_q;
        frame_sync_d = frame_sync_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        pix_count_d  = pix_count_q;

        addr_inc = we_q ? addr_q + 1'b1 : addr_q;
        addr_d   = addr_inc;
        keep     = ((x_in_q & X_MASK) == '0) && ((y_in_q & Y_MASK) == '0) &&
                   (x_in_q < H_LIM) && (y_in_q < V_LIM) && (addr_inc < FRAME_A);

        if (bus.vsync) begin
            // Blanking dominates href: everything per-frame restarts.
            addr_d     = '0;
            phase_d    = 1'b0;
            x_in_d     = '0;
            y_in_d     = '0;
            byte_cnt_d = '0;
            line_err_d = 1'b0;
            h_cnt_d    = '0;
            v_cnt_d    = '0;
            if (!vsync_q) begin
                pix_count_d  = addr_inc;
                frame_done_d = (addr_inc != '0);
            end
        end else begin
            if (vsync_q) begin
                mode_d       = bus.mode;
                frame_sync_d = 1'b1;
            end
            // Nothing is captured until a full vsync pulse has been seen.
            if (frame_sync_q) begin
                if (bus.href) begin
                    if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = bus.d;
                    end else begin
                        if (keep) begin
                            we_d    = 1'b1;
                            dout_d  = mode_q ? {8'h00, hi_q} : {hi_q, bus.d};
                            h_cnt_d = x_in_q >> DSH;
                            v_cnt_d = y_in_q >> DSH;
                        end
                        if (x_in_q != '1) x_in_d = x_in_q + 1'b1;
                    end
                end else begin
                    // A dangling high byte is simply dropped here.
                    phase_d = 1'b0;
                    if (href_q) begin
                        if (byte_cnt_q != LINE_B) line_err_d = 1'b1;
                        if (y_in_q != '1) y_in_d = y_in_q + 1'b1;
                        x_in_d     = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
        end
    end

    // State register; reset clears all state including the frame-sync flag.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            x_in_q       <= '0;
            y_in_q       <= '0;
            byte_cnt_q   <= '0;
            mode_q       <= 1'b0;
            frame_sync_q <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            pix_count_q  <= '0;
        end else begin
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            x_in_q       <= x_in_d;
            y_in_q       <= y_in_d;
            byte_cnt_q   <= byte_cnt_d;
            mode_q       <= mode_d;
            frame_sync_q <= frame_sync_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.dout       = dout_q;
    assign bus.we         = we_q;
    assign bus.wclk       = pclk;
    assign bus.h_cnt      = h_cnt_q;
    assign bus.v_cnt      = v_cnt_q;
    assign bus.frame_done = frame_done_q;
    assign bus.line_err   = line_err_q;
    assign bus.pix_count  = pix_count_q;
endmodule
